// File: rtl/aud_player.sv
// I2S DAC serialiser for the WM8731: buffers one sample through a valid/ready
// handshake and shifts it MSB-first on DACDAT, replaying it on both LRC halves.
module aud_player #(
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_dac_data,
  input  logic              i_dac_valid,
  output logic              o_dac_ready,
  output logic              o_aud_dacdat,
  output logic              o_underrun,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SHIFT = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               lrc_q;
  logic [DATA_W-1:0]  buf_q, buf_d;
  logic               buf_full_q, buf_full_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]  copy_q, copy_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               dacdat_q, dacdat_d;
  logic               underrun_q, underrun_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic               lrc_fall, lrc_rise, consume;
  logic [DATA_W-1:0]  load_src;

  assign lrc_fall = lrc_q & ~i_lrc;
  assign lrc_rise = ~lrc_q & i_lrc;
  assign load_src = buf_full_q ? buf_q : {DATA_W{1'b0}};

  // Next-state logic: LRC edge handling, bit serialisation and the one-entry buffer.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    shift_d    = shift_q;
    copy_d     = copy_q;
    bit_cnt_d  = bit_cnt_q;
    dacdat_d   = dacdat_q;
    underrun_d = 1'b0;
    consume    = 1'b0;

    if (!i_en) begin
      state_d  = S_IDLE;
      dacdat_d = 1'b0;
    end else if (lrc_fall && (state_q != S_IDLE)) begin
      // Left channel always starts a new word, taking a zero word if none is buffered
      copy_d     = load_src;
      shift_d    = {load_src[DATA_W-2:0], 1'b0};
      dacdat_d   = load_src[DATA_W-1];
      underrun_d = ~buf_full_q;
      consume    = buf_full_q;
      bit_cnt_d  = CNT_W'(1);
      state_d    = S_SHIFT;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d  = S_WAIT;
          dacdat_d = 1'b0;
        end
        S_WAIT: begin
          dacdat_d = 1'b0;
        end
        S_SHIFT, S_HOLD: begin
          if (lrc_rise) begin
            shift_d   = {copy_q[DATA_W-2:0], 1'b0};
            dacdat_d  = copy_q[DATA_W-1];
            bit_cnt_d = CNT_W'(1);
            state_d   = S_SHIFT;
          end else if (state_q == S_HOLD) begin
            dacdat_d = 1'b0;
          end else if (bit_cnt_q == CNT_W'(DATA_W)) begin
            dacdat_d = 1'b0;
            state_d  = S_HOLD;
          end else begin
            dacdat_d  = shift_q[DATA_W-1];
            shift_d   = {shift_q[DATA_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d  = S_IDLE;
          dacdat_d = 1'b0;
        end
      endcase
    end

    // Load and consume are exclusive: load needs an empty buffer, consume a full one
    if (consume) begin
      buf_full_d = 1'b0;
    end else if (i_dac_valid && ready_q) begin
      buf_d      = i_dac_data;
      buf_full_d = 1'b1;
    end else begin
      buf_full_d = buf_full_q;
    end

    ready_d = ~buf_full_d;
    busy_d  = (state_d == S_SHIFT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      lrc_q      <= 1'b0;
      buf_q      <= {DATA_W{1'b0}};
      buf_full_q <= 1'b0;
      shift_q    <= {DATA_W{1'b0}};
      copy_q     <= {DATA_W{1'b0}};
      bit_cnt_q  <= {CNT_W{1'b0}};
      dacdat_q   <= 1'b0;
      underrun_q <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      lrc_q      <= i_lrc;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      shift_q    <= shift_d;
      copy_q     <= copy_d;
      bit_cnt_q  <= bit_cnt_d;
      dacdat_q   <= dacdat_d;
      underrun_q <= underrun_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  assign o_dac_ready  = ready_q;
  assign o_aud_dacdat = dacdat_q;
  assign o_underrun   = underrun_q;
  assign o_busy       = busy_q;

endmodule
